mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the pipelined CPU's fetch stage (IF port) and memory stage (DM port).
- Arbitrates requests and sequences each memory access through a fixed latency.
- Returns read data with a one-cycle ack and drives per-port stall signals into the pipeline hazard logic.
- Sits between the cpu core and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 9 +
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter_starve_ctr.sv | 33 +++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic {GNT_IF, GNT_DM} grant_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// rtl/mem_port_arbiter_starve_ctr.sv - saturating count of DM wins over a waiting fetch
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   arb_fire,
  input  logic   if_req,
  input  grant_t gnt,
  output logic   force_if
);

  localparam int CNT_W = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (arb_fire) begin
      if (gnt == GNT_IF) begin
        cnt <= '0;
      end else if (if_req && !force_if) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign force_if = (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between the fetch and data ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t        state;
  arb_state_t        next_state;
  grant_t            grant;
  grant_t            arb_gnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              arb_fire;
  logic              done;
  logic              force_if;

  // DM has priority unless the fetch port has been passed over STARVE_MAX times in a row
  assign arb_gnt = (bus.if_req && (!bus.dm_req || force_if)) ? GNT_IF : GNT_DM;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .arb_fire (arb_fire),
    .if_req   (bus.if_req),
    .gnt      (arb_gnt),
    .force_if (force_if)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    arb_fire   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          arb_fire   = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (wait_cnt == WAIT_W'(1)) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= GNT_IF;
      wait_cnt    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (arb_fire) begin
        grant      <= arb_gnt;
        mem_addr_q <= (arb_gnt == GNT_IF) ? bus.if_addr : bus.dm_addr;
        mem_we_q   <= (arb_gnt == GNT_DM) && bus.dm_we;
        if (arb_gnt == GNT_DM) begin
          mem_wdata_q <= bus.dm_wdata;
        end
      end
      if (state == ISSUE) begin
        wait_cnt <= WAIT_W'(MEM_LAT);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Read data is a gated pass-through so both rdata ports read 0 outside their ack cycle
  assign bus.if_ack   = done && (grant == GNT_IF);
  assign bus.dm_ack   = done && (grant == GNT_DM);
  assign bus.if_rdata = bus.if_ack ? bus.mem_rdata : '0;
  assign bus.dm_rdata = bus.dm_ack ? bus.mem_rdata : '0;
  assign bus.if_stall = bus.if_req && !bus.if_ack;
  assign bus.dm_stall = bus.dm_req && !bus.dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level check of mem_port_arbiter at three latencies
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 3;
  localparam int N_CYC      = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;

    logic  reset;
    bit    done = 1'b0;
    string pfx;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(
      .ADDR_W     (64),
      .DATA_W     (64),
      .MEM_LAT    (LAT),
      .STARVE_MAX (STARVE_MAX)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    // memory contents as the bench expects them, and as the DUT actually wrote them
    logic [63:0] ref_mem [16];
    logic [63:0] ram     [16];
    logic [63:0] rsp_data [$];
    int          rsp_cyc  [$];

    // transaction schedule predicted from the latency rule
    int          issue_cyc, ack_cyc, free_cyc, starve;
    bit          t_dm, t_we;
    logic [63:0] t_addr, t_wdata, t_rdata;

    bit          if_on, dm_on, dm_dropped, dwe, do_reset, did_reset;
    logic [63:0] ia, da, dw;
    int          n_force, n_drop;

    initial begin
      for (int i = 0; i < 16; i++) begin
        ref_mem[i] = {$urandom, $urandom};
        ram[i]     = ref_mem[i];
      end
      if (gi == 0) begin
        ref_mem[0] = 64'hDEAD;
        ram[0]     = 64'hDEAD;
      end
      issue_cyc = -1; ack_cyc = -1; free_cyc = 0; starve = 0;
      t_dm = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
      n_force = 0; n_drop = 0; do_reset = 0; did_reset = 0; dm_dropped = 0;
      dm_on = 0; dwe = 0; da = '0; dw = '0;
      if_on = (gi == 0);
      ia    = (gi == 0) ? 64'h100 : '0;

      bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
      bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = {$urandom, $urandom};
      reset = 1'b1;
      #2 reset = 1'b0;
      #10;
      pfx = $sformatf("L%0d reset", LAT);
      check({pfx, " mem_en"},    bus.mem_en,    0);
      check({pfx, " mem_we"},    bus.mem_we,    0);
      check({pfx, " mem_addr"},  bus.mem_addr,  0);
      check({pfx, " mem_wdata"}, bus.mem_wdata, 0);
      check({pfx, " if_ack"},    bus.if_ack,    0);
      check({pfx, " dm_ack"},    bus.dm_ack,    0);
      check({pfx, " if_rdata"},  bus.if_rdata,  0);
      check({pfx, " dm_rdata"},  bus.dm_rdata,  0);
      check({pfx, " if_stall"},  bus.if_stall,  0);
      check({pfx, " dm_stall"},  bus.dm_stall,  0);

      for (int c = 0; c < N_CYC; c++) begin
        @(posedge clk);
        #1;
        pfx = $sformatf("L%0d c%0d", LAT, c);
        if (!reset) reset = 1'b1;

        // memory model: sample the access strobe, return read data LAT cycles later
        if (bus.mem_en) begin
          if (bus.mem_we) ram[bus.mem_addr[6:3]] = bus.mem_wdata;
          else begin
            rsp_data.push_back(ram[bus.mem_addr[6:3]]);
            rsp_cyc.push_back(c + LAT);
          end
        end
        if (rsp_cyc.size() > 0 && rsp_cyc[0] == c) begin
          bus.mem_rdata = rsp_data.pop_front();
          void'(rsp_cyc.pop_front());
        end else begin
          bus.mem_rdata = {$urandom, $urandom};
        end

        bus.if_req = if_on; bus.if_addr = ia;
        bus.dm_req = dm_on; bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dw;

        if (do_reset) begin
          reset = 1'b0;
          #1;
          check({pfx, " rst mem_en"},    bus.mem_en,    0);
          check({pfx, " rst mem_we"},    bus.mem_we,    0);
          check({pfx, " rst mem_addr"},  bus.mem_addr,  0);
          check({pfx, " rst mem_wdata"}, bus.mem_wdata, 0);
          check({pfx, " rst dm_ack"},    bus.dm_ack,    0);
          check({pfx, " rst dm_rdata"},  bus.dm_rdata,  0);
          issue_cyc = -1; ack_cyc = -1; free_cyc = c + 1; starve = 0;
          rsp_data.delete(); rsp_cyc.delete();
          do_reset = 0; did_reset = 1;
        end

        @(negedge clk);
        check({pfx, " mem_en"},   bus.mem_en,   (c == issue_cyc));
        check({pfx, " if_ack"},   bus.if_ack,   (c == ack_cyc) && !t_dm);
        check({pfx, " dm_ack"},   bus.dm_ack,   (c == ack_cyc) && t_dm);
        check({pfx, " if_stall"}, bus.if_stall, if_on && !((c == ack_cyc) && !t_dm));
        check({pfx, " dm_stall"}, bus.dm_stall, dm_on && !((c == ack_cyc) && t_dm));
        if (c == issue_cyc) begin
          check({pfx, " mem_addr"}, bus.mem_addr, t_addr);
          check({pfx, " mem_we"},   bus.mem_we,   t_we);
          if (t_we) check({pfx, " mem_wdata"}, bus.mem_wdata, t_wdata);
        end
        if (c == ack_cyc && !t_dm)         check({pfx, " if_rdata"}, bus.if_rdata, t_rdata);
        if (c == ack_cyc && t_dm && !t_we) check({pfx, " dm_rdata"}, bus.dm_rdata, t_rdata);

        if (c >= free_cyc && (if_on || dm_on)) begin
          automatic bit gif = if_on && (!dm_on || starve == STARVE_MAX);
          if (if_on && dm_on && gif) n_force++;
          if (gif) starve = 0;
          else if (if_on) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
          t_dm      = !gif;
          t_we      = !gif && dwe;
          t_addr    = gif ? ia : da;
          t_wdata   = dw;
          issue_cyc = c + 1;
          ack_cyc   = c + 1 + LAT;
          free_cyc  = c + 2 + LAT;
          if (t_we) ref_mem[t_addr[6:3]] = t_wdata;
          else      t_rdata = ref_mem[t_addr[6:3]];
        end

        if (if_on && bus.if_ack) if_on = 0;
        if (!if_on && $urandom_range(99) < 70) begin
          if_on = 1;
          ia    = {$urandom, $urandom} & ~64'h7;
        end

        if (bus.dm_ack) begin
          dm_on      = 0;
          dm_dropped = 0;
        end
        if (dm_on && t_dm && c >= issue_cyc && c < ack_cyc && $urandom_range(99) < 3) begin
          dm_on      = 0;
          dm_dropped = 1;
          n_drop++;
        end
        if (!did_reset && dm_on && t_dm && !t_we && c == issue_cyc && c > N_CYC / 2) do_reset = 1;
        if (!dm_on && !dm_dropped && !(gi == 0 && c < 3) && $urandom_range(99) < 70) begin
          dm_on = 1;
          dwe   = 1'($urandom_range(1));
          da    = {$urandom, $urandom} & ~64'h7;
          dw    = {$urandom, $urandom};
        end
      end

      pfx = $sformatf("L%0d end", LAT);
      check({pfx, " reset_injected"}, did_reset,  1);
      check({pfx, " forced_if_win"},  n_force > 0, 1);
      check({pfx, " dropped_req"},    n_drop > 0,  1);
      done = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < N_CYC + 2000; t++) begin
      @(posedge clk);
      if (g_lat[0].done && g_lat[1].done && g_lat[2].done) break;
    end
    check("all_instances_done", {g_lat[2].done, g_lat[1].done, g_lat[0].done}, 3'b111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
